leaf_user_fifo: RTL
===================

// Module: leaf_user_fifo
// PURPOSE
//   Elastic buffer on the user side of a BFT leaf: between leaf_interface output (dout/vld/ack)
//   and user_kernel Input_*_V_V (ap_vld/ap_ack), or between user_kernel Output_*_V_V and leaf_interface.
//   Decouples the kernel from interface stalls and absorbs bursts of up to 2**DEPTH_BITS words.
//   Data is passed through unmodified and in order.
// PARAMETERS
//   DATA_BITS   32  payload width; matches leaf_interface PAYLOAD_BITS
//   DEPTH_BITS  4   log2 of depth; depth = 2**DEPTH_BITS words (16); legal range 1..7
// PORTS
//   clk        in   1               single clock for the whole leaf
//   reset      in   1               asynchronous, active-low; 0 = in reset
//   flush      in   1               synchronous flush; active-high; discards all stored words
//   din        in   DATA_BITS       write data from producer
//   din_vld    in   1               producer has a valid word on din
//   din_ack    out  1               buffer accepts din this cycle
//   dout       out  DATA_BITS       head-of-queue word to consumer
//   dout_vld   out  1               dout holds a valid word
//   dout_ack   in   1               consumer takes dout this cycle
//   count      out  DEPTH_BITS+1    number of stored words, 0..2**DEPTH_BITS
// BEHAVIOUR
//   Handshake: a word transfers on a rising clk edge where vld and ack are both 1 (either side).
//     The producer holds din while din_vld=1 && din_ack=0. Ack with vld=0 is a no-op.
//   Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, dout_vld=0, din_ack=0, dout=0.
//     Storage contents are not reset. First din_ack=1 appears in the first cycle after reset deasserts.
//   din_ack  = (count != DEPTH) && !flush && reset deasserted. Depends only on registered state and flush.
//   dout_vld = (count != 0). It never depends combinationally on dout_ack.
//   dout     = mem[rd_ptr] when dout_vld=1, else 0 (forced).
//   push = din_vld && din_ack: mem[wr_ptr] <= din and wr_ptr++ at the edge.
//   pop = dout_vld && dout_ack: rd_ptr++ at the edge.
//   count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
//   Latency: a word pushed into an empty buffer at edge N appears on dout with dout_vld=1 after edge N.
//     It can be popped at edge N+1. There is no same-cycle bypass.
//   Pointers are DEPTH_BITS wide and wrap modulo 2**DEPTH_BITS with no special case at wrap.
//   Full (count=DEPTH): din_ack=0, so no push can occur. A pop in this cycle frees one slot.
//     din_ack then returns to 1 in the next cycle.
//   Empty (count=0): dout_vld=0. dout_ack is ignored and no pop occurs.
//   Flush: at the edge where flush=1, wr_ptr, rd_ptr and count go to 0. Any simultaneous pop is void.
//     din_ack=0 in the flush cycle, so no push is lost silently.
//     dout_vld=0 from the cycle after the flush edge.
//   Async reset mid-transfer: all state clears immediately and in-flight words are lost.
//     The producer must re-present the word after reset deasserts.
//   Invariant: count == (wr_ptr - rd_ptr) mod 2**DEPTH_BITS, except when full.
//     When full, count=DEPTH and the pointers are equal.
// STRUCTURE
//   Shared header leaf_defs.vh holds the BFT leaf constants:
//     LEAF_PAYLOAD_BITS=32, LEAF_PACKET_BITS=49, LEAF_FIFO_DEPTH_BITS=4.
//   Sub-module leaf_fifo_ram: 2**DEPTH_BITS x DATA_BITS register array.
//     One synchronous write port and one asynchronous read port, with no reset.
//     It maps to LUTRAM or flops.
//   The top level owns pointers, count, handshake logic and the dout zero-mux.
//   Instantiation in leaf_N: one instance per in-port and one per out-port.
// TESTING
//   1 Reset then idle: after reset release -> din_ack=1, dout_vld=0, count=0, dout=0.
//   2 Fill: push 0x00000001..0x00000010 with dout_ack=0.
//     -> count reaches 16 and din_ack=0 in the cycle after the 16th push.
//     -> a 17th word 0xDEADBEEF is held and not accepted.
//   3 Drain in order with dout_ack=1: dout sequence is 1..16, count falls to 0, dout_vld=0 after the last pop.
//     -> 0xDEADBEEF is accepted on the first free slot and emerges 17th.
//   4 Streaming: din_vld=1 and dout_ack=1 continuously with incrementing data.
//     -> after 1-cycle fill latency, count stays at 1, one word per cycle, 100 words out in order.
//     -> pointer wrap is exercised more than 6 times.
//   5 Flush while count=5 and push+pop asserted in the same cycle.
//     -> din_ack=0 that cycle; count=0 and dout_vld=0 next cycle.
//     -> the next pushed word 0xA5A5A5A5 is the first dout.
//   6 Async reset asserted mid-burst, between edges.
//     -> dout_vld and din_ack drop immediately and count=0.
//     -> after release, normal operation resumes with no stale words.
//   Random stall scoreboard: random din_vld/dout_ack at 30-70% duty for 10k cycles.
//     -> no loss, no duplication, order preserved, count invariant holds.

Source files
------------

// File: rtl/leaf_user_fifo_pkg.sv
// Shared BFT leaf constants and sizing helpers for the user-side elastic buffer.
package leaf_user_fifo_pkg;

    localparam int unsigned LEAF_PAYLOAD_BITS    = 32;
    localparam int unsigned LEAF_PACKET_BITS     = 49;
    localparam int unsigned LEAF_FIFO_DEPTH_BITS = 4;

    // Number of words held by a buffer with the given pointer width.
    function automatic int unsigned fifo_depth(input int unsigned depth_bits);
        return 32'd1 << depth_bits;
    endfunction

endpackage

// File: rtl/leaf_fifo_ram.sv
// Storage array for leaf_user_fifo: one synchronous write port and one
// asynchronous read port. No reset, so it can map onto LUTRAM or plain flops.
module leaf_fifo_ram
    import leaf_user_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS  = LEAF_PAYLOAD_BITS,
    parameter int unsigned DEPTH_BITS = LEAF_FIFO_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0]  rdata
);

    logic [DATA_BITS-1:0] mem [fifo_depth(DEPTH_BITS)];

    // Synchronous write of the accepted word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the head-of-queue slot.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/leaf_user_fifo.sv
// Elastic buffer between a BFT leaf interface and a user kernel port.
// Passes words through unmodified and in order; owns pointers, occupancy
// count, the vld/ack handshakes and the zero-forcing of dout when empty.
module leaf_user_fifo
    import leaf_user_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS  = LEAF_PAYLOAD_BITS,
    parameter int unsigned DEPTH_BITS = LEAF_FIFO_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  din_vld,
    output logic                  din_ack,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  dout_vld,
    input  logic                  dout_ack,
    output logic [DEPTH_BITS:0]   count
);

    localparam int unsigned          CNT_BITS   = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);
    localparam logic [CNT_BITS-1:0]   CNT_ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]   FULL_COUNT = CNT_BITS'(fifo_depth(DEPTH_BITS));

    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DATA_BITS-1:0]  rd_data;
    logic                  run;
    logic                  push;
    logic                  pop;

    // Registered "out of reset" flag: keeps din_ack free of a combinational
    // path from the reset pin, so the first ack shows one edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Handshake qualifiers and the zero-forced output word.
    always_comb begin
        din_ack  = run && (count != FULL_COUNT) && !flush;
        dout_vld = (count != '0);
        push     = din_vld && din_ack;
        pop      = dout_vld && dout_ack;
        dout     = dout_vld ? rd_data : '0;
    end

    // Pointer and occupancy update; flush wins over any simultaneous pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    leaf_fifo_ram #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
